uart_result_tx: RTL and testbench

//   UART 8N1 transmitter for the result byte the register file exposes on uart_result_data.
//   It pairs with the UART receive path that feeds uart_signal/uart_flag/uart_rx_data into the ID stage.
//   It serialises one byte per request onto uart_txd and has a one-entry holding register.
//   A second request can therefore queue while a frame is in flight.

---
 rtl/uart_result_tx.sv | 145 ++++++++++++++
 tb/tb_uart_result_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_result_tx.sv
// uart_result_tx: UART 8N1 transmitter for the register-file result byte.
// One frame in flight plus a one-entry holding register, so a second byte
// can be queued while the first is still being shifted out.
`timescale 1ns/1ps

module uart_result_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_txd
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shifter;
  logic [7:0]      hold_data;
  logic            hold_valid;

  logic bit_tick;
  logic accept;
  logic to_hold;

  assign bit_tick = (baud_cnt == CNT_LAST);
  assign accept   = tx_start && tx_ready;
  // A request goes to the holding register unless the shifter can take it
  // right now: either the line is idle or the current stop bit ends this cycle.
  assign to_hold  = accept && (state != IDLE) && !((state == STOP) && bit_tick);

  // Frame sequencer, bit timing and registered line/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shifter    <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      uart_txd   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments throughout; a later assignment in this
      // block overrides these defaults for the same edge, which is how the
      // one-cycle tx_done pulse and the counter wrap are expressed.
      tx_done  <= 1'b0;
      baud_cnt <= bit_tick ? '0 : baud_cnt + CW'(1);

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (accept) begin
            shifter  <= tx_data;
            state    <= START;
            uart_txd <= 1'b0;
            tx_busy  <= 1'b1;
          end else if (hold_valid) begin
            shifter    <= hold_data;
            hold_valid <= 1'b0;
            tx_ready   <= 1'b1;
            state      <= START;
            uart_txd   <= 1'b0;
            tx_busy    <= 1'b1;
          end
        end

        START: begin
          if (bit_tick) begin
            state    <= DATA;
            bit_idx  <= '0;
            uart_txd <= shifter[0];
            shifter  <= {1'b0, shifter[7:1]};
          end
        end

        DATA: begin
          if (bit_tick) begin
            if (bit_idx == 3'd7) begin
              state    <= STOP;
              uart_txd <= 1'b1;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              uart_txd <= shifter[0];
              shifter  <= {1'b0, shifter[7:1]};
            end
          end
        end

        STOP: begin
          if (bit_tick) begin
            tx_done <= 1'b1;
            if (hold_valid) begin
              // Queued byte follows immediately, no idle gap on the line.
              shifter    <= hold_data;
              hold_valid <= 1'b0;
              tx_ready   <= 1'b1;
              state      <= START;
              uart_txd   <= 1'b0;
            end else if (accept) begin
              shifter  <= tx_data;
              state    <= START;
              uart_txd <= 1'b0;
            end else begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
          end
        end

        default: begin
          state    <= IDLE;
          uart_txd <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase

      // Second request while a frame is in flight parks in the hold register.
      if (to_hold) begin
        hold_data  <= tx_data;
        hold_valid <= 1'b1;
        tx_ready   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_result_tx.sv
// tb_uart_result_tx: directed bench for uart_result_tx with DIV=16.
// Accepted bytes are pushed to a queue; a line monitor decodes each frame
// from uart_txd and compares it against the queue head.
`timescale 1ns/1ps

module tb_uart_result_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       uart_txd;

  int         n_checks = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_result_tx #(
    .CLK_FREQ (16),
    .BAUD     (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .uart_txd (uart_txd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for bit slot b (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  task automatic send(input logic [7:0] d, input bit expect_accept);
    tx_data  = d;
    tx_start = 1'b1;
    if (expect_accept) exp_q.push_back(d);
    tick();
    tx_start = 1'b0;
    tx_data  = ~d;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < 400) begin
      tick();
      n++;
    end
    check(tag, (n < 400), 1);
  endtask

  // Line monitor: decodes frames mid-bit and scores them against the queue.
  logic       mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_active = 1'b0;
      mon_cnt    = 0;
    end else begin
      if (tx_done) done_cnt++;
      if (!mon_active) begin
        if (uart_txd === 1'b0) begin
          mon_active = 1'b1;
          mon_cnt    = 0;
        end
      end else begin
        mon_cnt++;
      end
      if (mon_active && (mon_cnt % 16 == 8)) begin
        if (mon_cnt / 16 == 0) begin
          check("mon_start_bit", uart_txd, 0);
        end else if (mon_cnt / 16 <= 8) begin
          mon_byte[mon_cnt/16 - 1] = uart_txd;
        end else begin
          check("mon_stop_bit", uart_txd, 1);
          if (exp_q.size() == 0) check("mon_frame_expected", 0, 1);
          else check("mon_frame_byte", mon_byte, exp_q.pop_front());
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int n;

    // 1. Reset held, then released; line stays idle with no requests.
    repeat (3) tick();
    check("rst_outputs", {uart_txd, tx_ready, tx_busy, tx_done}, 4'b1100);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_outputs", {uart_txd, tx_ready, tx_busy, tx_done}, 4'b1100);
    end

    // 2. Single 0xA5 frame, cycle-exact.
    d0 = done_cnt;
    send(8'hA5, 1'b1);
    for (int i = 0; i < 160; i++) begin
      check("t2_txd", uart_txd, frame_bit(8'hA5, i / 16));
      check("t2_busy", tx_busy, 1);
      check("t2_done_low", tx_done, 0);
      tick();
    end
    check("t2_done_pulse", tx_done, 1);
    check("t2_busy_end", tx_busy, 0);
    check("t2_txd_idle", uart_txd, 1);
    tick();
    check("t2_done_single", tx_done, 0);
    check("t2_done_count", done_cnt - d0, 1);

    // 3. 0x3C then 0xFF queued at T+5; second frame follows with no gap.
    d0 = done_cnt;
    send(8'h3C, 1'b1);
    repeat (4) tick();
    check("t3_ready_before", tx_ready, 1);
    send(8'hFF, 1'b1);
    check("t3_ready_low", tx_ready, 0);
    repeat (154) tick();
    check("t3_stop_bit", uart_txd, 1);
    check("t3_ready_still_low", tx_ready, 0);
    tick();
    check("t3_back_to_back_start", uart_txd, 0);
    check("t3_done_first", tx_done, 1);
    check("t3_ready_again", tx_ready, 1);
    check("t3_busy_kept", tx_busy, 1);
    wait_idle("t3_timeout");
    tick();
    check("t3_done_count", done_cnt - d0, 2);

    // 4. Third request while the hold register is full is dropped.
    d0 = done_cnt;
    send(8'h01, 1'b1);
    repeat (4) tick();
    send(8'h02, 1'b1);
    check("t4_ready_full", tx_ready, 0);
    send(8'h03, 1'b0);
    wait_idle("t4_timeout");
    repeat (40) tick();
    check("t4_no_third_frame", tx_busy, 0);
    check("t4_done_count", done_cnt - d0, 2);

    // 5. Reset mid-frame forces the line high at once and loses the frame.
    d0 = done_cnt;
    send(8'h00, 1'b1);
    repeat (39) tick();
    check("t5_mid_frame_low", uart_txd, 0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_txd", uart_txd, 1);
    check("t5_rst_busy", tx_busy, 0);
    check("t5_rst_ready", tx_ready, 1);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (200) tick();
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_line_idle", uart_txd, 1);
    d0 = done_cnt;
    send(8'h5A, 1'b1);
    wait_idle("t5_timeout");
    tick();
    check("t5_clean_frame_done", done_cnt - d0, 1);

    // 6. Request in the tx_done cycle with hold empty starts at the next edge.
    d0 = done_cnt;
    send(8'hC3, 1'b1);
    n = 0;
    while (!tx_done && n < 200) begin
      tick();
      n++;
    end
    check("t6_done_seen", tx_done, 1);
    send(8'h96, 1'b1);
    check("t6_start_bit", uart_txd, 0);
    check("t6_busy", tx_busy, 1);
    repeat (16) tick();
    check("t6_first_data_bit", uart_txd, frame_bit(8'h96, 1));
    wait_idle("t6_timeout");
    tick();
    check("t6_done_count", done_cnt - d0, 2);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
